// File: rtl/soc_system_cam_pkg.sv
// Shared types and widths for the camera line writer.
package soc_system_cam_pkg;

  localparam int unsigned PIX_W         = 16;
  localparam int unsigned LANES         = 4;
  localparam int unsigned DATA_W        = 64;
  localparam int unsigned BE_W          = DATA_W / 8;
  localparam int unsigned LANE_W        = 2;
  localparam int unsigned BYTES_PER_PIX = PIX_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOP,
    PACK,
    WRITE
  } state_t;

endpackage

// File: rtl/soc_system_cam_pixel_packer.sv
// Packs 16-bit pixels into lanes of a 64-bit word and tracks the byte enables.
module soc_system_cam_pixel_packer
  import soc_system_cam_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic                clear,
  input  logic [PIX_W-1:0]    pixel,
  output logic [LANE_W-1:0]   lane,
  output logic [DATA_W-1:0]   writedata,
  output logic [BE_W-1:0]     byteenable
);

  // Clear wins over load; the FSM never asserts both in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane       <= '0;
      writedata  <= '0;
      byteenable <= '0;
    end else if (load_en) begin
      writedata[PIX_W*32'(lane) +: PIX_W]                 <= pixel;
      byteenable[BYTES_PER_PIX*32'(lane) +: BYTES_PER_PIX] <= '1;
      lane                                                <= lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/soc_system_cam_line_writer.sv
// Avalon-MM write master: packs one Avalon-ST camera line into 64-bit words
// and writes them to on-chip memory starting at BASE_ADDR.
module soc_system_cam_line_writer
  import soc_system_cam_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   line_words,
  output logic              overflow,
  input  logic [15:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic [ADDR_W-1:0] avm_address,
  output logic [7:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [63:0]       avm_writedata,
  input  logic              avm_waitrequest
);

  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t              state;
  state_t              next_state;
  logic                accept_c;
  logic                load_en_c;
  logic                clear_c;
  logic                wr_done_c;
  logic [LANE_W-1:0]   lane;
  logic                word_eop;
  logic [CNT_W-1:0]    word_cnt;
  logic [CNT_W-1:0]    word_cnt_inc_c;

  assign accept_c       = snk_valid && snk_ready;
  assign word_cnt_inc_c = (word_cnt == CNT_MAX) ? word_cnt : word_cnt + CNT_W'(1);

  soc_system_cam_pixel_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en_c),
    .clear      (clear_c),
    .pixel      (snk_data),
    .lane       (lane),
    .writedata  (avm_writedata),
    .byteenable (avm_byteenable)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and per-cycle strobes for the packer and bookkeeping.
  always_comb begin
    next_state = state;
    load_en_c  = 1'b0;
    clear_c    = 1'b0;
    wr_done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = WAIT_SOP;
          clear_c    = 1'b1;
        end
      end
      WAIT_SOP: begin
        if (accept_c && snk_sop) begin
          load_en_c  = 1'b1;
          next_state = snk_eop ? WRITE : PACK;
        end
      end
      PACK: begin
        if (accept_c) begin
          load_en_c = 1'b1;
          if (snk_eop || lane == LANE_W'(LANES - 1)) next_state = WRITE;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          wr_done_c  = 1'b1;
          clear_c    = 1'b1;
          next_state = word_eop ? IDLE : PACK;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      line_words     <= '0;
      snk_ready      <= 1'b0;
      avm_write      <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_address    <= BASE;
      word_cnt       <= '0;
      word_eop       <= 1'b0;
    end else begin
      snk_ready      <= (next_state == WAIT_SOP) || (next_state == PACK);
      avm_write      <= (next_state == WRITE);
      avm_chipselect <= (next_state == WRITE);
      done           <= 1'b0;

      if (state == IDLE && start) begin
        busy        <= 1'b1;
        overflow    <= 1'b0;
        word_cnt    <= '0;
        avm_address <= BASE;
      end

      if (load_en_c) word_eop <= snk_eop;

      if (wr_done_c) begin
        word_cnt <= word_cnt_inc_c;
        if (avm_address == LAST_ADDR) begin
          avm_address <= '0;
          overflow    <= 1'b1;
        end else begin
          avm_address <= avm_address + ADDR_W'(1);
        end
        if (word_eop) begin
          line_words <= word_cnt_inc_c;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_system_cam_line_writer.sv
// Directed bench: two writers (BASE_ADDR 0 and 510) run in lockstep on shared
// stimulus; a packing model queues expected words and a monitor checks writes.
module tb_soc_system_cam_line_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] snk_data;
  logic        snk_valid;
  logic        snk_sop;
  logic        snk_eop;
  logic        wreq;

  logic        busy       [2];
  logic        done       [2];
  logic [9:0]  line_words [2];
  logic        overflow   [2];
  logic        snk_ready  [2];
  logic [8:0]  addr       [2];
  logic [7:0]  be         [2];
  logic        cs         [2];
  logic        wr         [2];
  logic [63:0] wdata      [2];

  always #5 clk = ~clk;

  soc_system_cam_line_writer #(.ADDR_W(9), .DEPTH(512), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
    .line_words(line_words[0]), .overflow(overflow[0]), .snk_data(snk_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready[0]), .snk_sop(snk_sop), .snk_eop(snk_eop),
    .avm_address(addr[0]), .avm_byteenable(be[0]), .avm_chipselect(cs[0]),
    .avm_write(wr[0]), .avm_writedata(wdata[0]), .avm_waitrequest(wreq)
  );

  soc_system_cam_line_writer #(.ADDR_W(9), .DEPTH(512), .BASE_ADDR(510)) dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
    .line_words(line_words[1]), .overflow(overflow[1]), .snk_data(snk_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready[1]), .snk_sop(snk_sop), .snk_eop(snk_eop),
    .avm_address(addr[1]), .avm_byteenable(be[1]), .avm_chipselect(cs[1]),
    .avm_write(wr[1]), .avm_writedata(wdata[1]), .avm_waitrequest(wreq)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  be;
    int          idx;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors     = 0;
  int  miscompares = 0;
  int  done_cnt [2] = '{0, 0};

  logic [63:0] m_data;
  logic [7:0]  m_be;
  int          m_lane;
  bit          m_in_line;
  int          m_idx;

  bit          stalled [2] = '{0, 0};
  logic [8:0]  st_addr [2];
  logic [63:0] st_data [2];
  logic [7:0]  st_be   [2];

  function automatic int base_of(input int d);
    return (d == 1) ? 510 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: compares each completing write against the model queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) if (done[d] === 1'b1) done_cnt[d]++;
    if (reset !== 1'b0) begin
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (wr[d] === 1'b1) begin
          check("chipselect_eq_write", 64'(cs[d]), 64'd1);
          check("ready_low_in_write", 64'(snk_ready[d]), 64'd0);
          if (stalled[d]) begin
            check("stall_addr_stable", 64'(addr[d]), 64'(st_addr[d]));
            check("stall_data_stable", wdata[d], st_data[d]);
            check("stall_be_stable", 64'(be[d]), 64'(st_be[d]));
          end
        end
      end
      if (wr[0] === 1'b1 && wreq === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("lockstep_write", 64'(wr[1]), 64'd1);
          for (int d = 0; d < 2; d++) begin
            check("write_data", wdata[d], mon_e.data);
            check("write_be", 64'(be[d]), 64'(mon_e.be));
            check("write_addr", 64'(addr[d]), 64'((base_of(d) + mon_e.idx) % 512));
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        stalled[d] = (wr[d] === 1'b1) && (wreq === 1'b1);
        st_addr[d] = addr[d];
        st_data[d] = wdata[d];
        st_be[d]   = be[d];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start     = 1'b0;
    m_idx     = 0;
    m_in_line = 1'b0;
    m_lane    = 0;
    m_data    = '0;
    m_be      = '0;
    for (int d = 0; d < 2; d++) check("busy_after_start", 64'(busy[d]), 64'd1);
  endtask

  // Drive one beat until accepted, then update the packing model.
  task automatic send(input logic [15:0] px, input bit sop, input bit eop);
    bit ok;
    ok        = 1'b0;
    snk_data  = px;
    snk_sop   = sop;
    snk_eop   = eop;
    snk_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (snk_ready[0] === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    if (m_in_line || sop) begin
      m_in_line = 1'b1;
      m_data[16*m_lane +: 16] = px;
      m_be[2*m_lane +: 2]     = 2'b11;
      m_lane++;
      if (m_lane == 4 || eop) begin
        exp_q.push_back('{m_data, m_be, m_idx});
        m_idx++;
        m_lane = 0;
        m_data = '0;
        m_be   = '0;
        if (eop) m_in_line = 1'b0;
      end
    end
  endtask

  task automatic send_line(input int n, input logic [15:0] first);
    for (int i = 0; i < n; i++) send(first + 16'(i), i == 0, i == n - 1);
  endtask

  task automatic finish_line(input int nwords);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    for (int d = 0; d < 2; d++) begin
      check("done_lockstep", 64'(done[d]), 64'd1);
      check("busy_low_at_done", 64'(busy[d]), 64'd0);
      check("line_words", 64'(line_words[d]), 64'(nwords));
      check("overflow", 64'(overflow[d]), 64'((base_of(d) + nwords) >= 512));
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("done_one_cycle", 64'(done[d]), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    int dc0;
    reset     = 1'b1;
    start     = 1'b0;
    snk_data  = '0;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    wreq      = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", 64'(busy[d]), 64'd0);
      check("rst_done", 64'(done[d]), 64'd0);
      check("rst_overflow", 64'(overflow[d]), 64'd0);
      check("rst_write", 64'(wr[d]), 64'd0);
      check("rst_chipselect", 64'(cs[d]), 64'd0);
      check("rst_ready", 64'(snk_ready[d]), 64'd0);
      check("rst_addr", 64'(addr[d]), 64'(base_of(d)));
      check("rst_be", 64'(be[d]), 64'd0);
      check("rst_data", wdata[d], 64'd0);
      check("rst_line_words", 64'(line_words[d]), 64'd0);
    end
    reset = 1'b0;
    tick();

    // Two full words, 0x0001..0x0008.
    do_start();
    send_line(8, 16'h0001);
    finish_line(2);

    // Six pixels: partial second word.
    do_start();
    send_line(6, 16'h0011);
    finish_line(2);

    // Waitrequest held for three cycles on the first write.
    do_start();
    wreq = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i), i == 0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("stall_write_high", 64'(wr[d]), 64'd1);
    end
    @(posedge clk);
    #1;
    wreq = 1'b0;
    @(negedge clk);
    check("stall_4th_cycle_write", 64'(wr[0]), 64'd1);
    @(posedge clk);
    #1;
    check("stall_write_released", 64'(wr[0]), 64'd0);
    for (int i = 4; i < 8; i++) send(16'h0100 + 16'(i), 1'b0, i == 7);
    finish_line(2);

    // Twelve pixels: dut1 wraps 510, 511, 0.
    do_start();
    send_line(12, 16'h0200);
    finish_line(3);

    // Beats before sop are discarded.
    do_start();
    send(16'hAAAA, 1'b0, 1'b0);
    send(16'hBBBB, 1'b0, 1'b0);
    send_line(4, 16'h0301);
    finish_line(1);

    // Reset during a stalled write.
    do_start();
    wreq = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0400 + 16'(i), i == 0, 1'b0);
    check("pre_reset_write", 64'(wr[0]), 64'd1);
    dc0   = done_cnt[0];
    reset = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      check("mid_reset_write", 64'(wr[d]), 64'd0);
      check("mid_reset_busy", 64'(busy[d]), 64'd0);
      check("mid_reset_addr", 64'(addr[d]), 64'(base_of(d)));
      check("mid_reset_ready", 64'(snk_ready[d]), 64'd0);
    end
    reset = 1'b0;
    wreq  = 1'b0;
    exp_q.delete();
    repeat (5) tick();
    check("no_done_after_reset", 64'(done_cnt[0]), 64'(dc0));
    check("idle_after_reset", 64'(wr[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
